cdb_arb: RTL

CDB_ARB -- requirements
Module: cdb_arb

---
 rtl/cdb_arb_pkg.sv | 23 ++
 rtl/cdb_arb_rr_sel3.sv | 38 +++
 rtl/cdb_arb.sv | 108 ++++++++++
 3 files changed

// File: rtl/cdb_arb_pkg.sv
// rtl/cdb_arb_pkg.sv - shared completion/broadcast packet types for the CDB arbiter
package cdb_arb_pkg;

    localparam int PR_W  = 6;
    localparam int ROB_W = 5;

    typedef logic [PR_W-1:0]  pr_t;
    typedef logic [ROB_W-1:0] rob_t;

    typedef struct packed {
        pr_t         dest_pr;
        logic [31:0] value;
        rob_t        rob_idx;
    } FU_COMPLETE_PACKET;

    // Packed so that t0 sits in the low bits, matching slot order.
    typedef struct packed {
        pr_t t2;
        pr_t t1;
        pr_t t0;
    } CDB_T_PACKET;

endpackage

// File: rtl/cdb_arb_rr_sel3.sv
// rtl/cdb_arb_rr_sel3.sv - rotating selector returning up to NUM_GNT one-hot grants
module rr_sel3 #(
    parameter int NUM_FU  = 8,
    parameter int NUM_GNT = 3,
    localparam int PTR_W  = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0]               req,
    input  logic [PTR_W-1:0]                ptr,
    output logic [NUM_GNT-1:0][NUM_FU-1:0]  grant,
    output logic [PTR_W-1:0]                last_idx,
    output logic                            any_grant
);

    int               cnt;
    logic [PTR_W-1:0] idx;

    // Walk from ptr upward; the k-th request found lands in grant slot k.
    always_comb begin
        grant    = '0;
        last_idx = '0;
        cnt      = 0;
        idx      = '0;
        for (int off = 0; off < NUM_FU; off++) begin
            idx = PTR_W'((int'(ptr) + off) % NUM_FU);
            if (req[idx] && cnt < NUM_GNT) begin
                for (int g = 0; g < NUM_GNT; g++) begin
                    if (cnt == g) begin
                        grant[g][idx] = 1'b1;
                    end
                end
                last_idx = idx;
                cnt      = cnt + 1;
            end
        end
        any_grant = (cnt != 0);
    end

endmodule

// File: rtl/cdb_arb.sv
// rtl/cdb_arb.sv - per-FU holding registers arbitrated onto a 3-slot common data bus
module cdb_arb
    import cdb_arb_pkg::*;
#(
    parameter int NUM_FU = 8,
    parameter int CDB_W  = 3
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               squash,
    input  logic [NUM_FU-1:0]                  fu_done,
    input  FU_COMPLETE_PACKET [NUM_FU-1:0]     fu_packet,
    output logic [NUM_FU-1:0]                  fu_accept,
    output CDB_T_PACKET                        cdb_t,
    output logic [CDB_W-1:0]                   cdb_valid,
    output logic [CDB_W-1:0][31:0]             cdb_value,
    output logic [CDB_W-1:0][ROB_W-1:0]        cdb_rob_idx
);

    localparam int PTR_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0]                 hold_valid;
    FU_COMPLETE_PACKET [NUM_FU-1:0]    hold_pkt;
    logic [PTR_W-1:0]                  rr_ptr;
    logic [CDB_W-1:0][NUM_FU-1:0]      slot_grant;
    logic [NUM_FU-1:0]                 grant;
    logic [PTR_W-1:0]                  last_idx;
    logic                              any_grant;
    FU_COMPLETE_PACKET [CDB_W-1:0]     slot_pkt;
    logic [CDB_W-1:0][PR_W-1:0]        cdb_tag;

    rr_sel3 #(
        .NUM_FU  (NUM_FU),
        .NUM_GNT (CDB_W)
    ) u_sel (
        .req       (hold_valid),
        .ptr       (rr_ptr),
        .grant     (slot_grant),
        .last_idx  (last_idx),
        .any_grant (any_grant)
    );

    // Ungranted slots keep an all-zero payload so the bus idles at zero.
    always_comb begin
        grant    = '0;
        slot_pkt = '0;
        for (int k = 0; k < CDB_W; k++) begin
            grant = grant | slot_grant[k];
            for (int i = 0; i < NUM_FU; i++) begin
                if (slot_grant[k][i]) begin
                    slot_pkt[k] = hold_pkt[i];
                end
            end
        end
    end

    // A granted entry drains this edge, so it can be refilled in the same cycle.
    assign fu_accept = ~{NUM_FU{squash}} & (~hold_valid | grant);

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid  <= '0;
            rr_ptr      <= '0;
            cdb_valid   <= '0;
            cdb_tag     <= '0;
            cdb_value   <= '0;
            cdb_rob_idx <= '0;
        end else if (squash) begin
            hold_valid  <= '0;
            cdb_valid   <= '0;
            cdb_tag     <= '0;
            cdb_value   <= '0;
            cdb_rob_idx <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_done[i] && fu_accept[i]) begin
                    hold_valid[i] <= 1'b1;
                end else if (grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
            for (int k = 0; k < CDB_W; k++) begin
                cdb_valid[k]   <= |slot_grant[k];
                cdb_tag[k]     <= slot_pkt[k].dest_pr;
                cdb_value[k]   <= slot_pkt[k].value;
                cdb_rob_idx[k] <= slot_pkt[k].rob_idx;
            end
            if (any_grant) begin
                rr_ptr <= (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_done[i] && fu_accept[i]) begin
                    hold_pkt[i] <= fu_packet[i];
                end
            end
        end
    end

    assign cdb_t.t0 = cdb_tag[0];
    assign cdb_t.t1 = cdb_tag[1];
    assign cdb_t.t2 = cdb_tag[2];

endmodule
